// File: rtl/led_pattern_pkg.sv
// Shared constants and helpers for the LED pattern driver and its tick generator.
package led_pattern_pkg;

  localparam logic [2:0] MODE_STATIC = 3'd0;
  localparam logic [2:0] MODE_ROTL   = 3'd1;
  localparam logic [2:0] MODE_ROTR   = 3'd2;
  localparam logic [2:0] MODE_BOUNCE = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] MODE_COUNT  = 3'd5;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Counter width for a divide-by-div tick; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_pattern_if.sv
// Register-bank side of the LED pattern driver: controls in, LED drive and step pulse out.
interface led_pattern_if #(
  parameter int LED_WIDTH = 8
);
  logic                 En;
  logic [2:0]           Mode;
  logic [LED_WIDTH-1:0] DataIn;
  logic                 Load;
  logic [LED_WIDTH-1:0] LEDOut;
  logic                 StepTick;

  modport master (output En, Mode, DataIn, Load, input LEDOut, StepTick);
  modport slave  (input En, Mode, DataIn, Load, output LEDOut, StepTick);
endinterface

// File: rtl/led_tick_gen.sv
// Single-cycle clock-enable generator: Tick is high on every TICK_DIV-th enabled cycle.
module led_tick_gen
  import led_pattern_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Disable and Clear both restart the period so the next tick is a full TICK_DIV away.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!En || Clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  assign Tick = En && (cnt_q == LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// LED pattern register stepped by a slow clock-enable; supports static, rotate, bounce,
// blink and count modes with load/mode-change/step priority and registered outputs.
module led_pattern_driver
  import led_pattern_pkg::*;
#(
  parameter int LED_WIDTH = 8,
  parameter int TICK_DIV  = 100000000
) (
  input logic          Clk,
  input logic          Rst,
  led_pattern_if.slave bus
);

  localparam int W = LED_WIDTH;

  logic [W-1:0] pattern_q, pattern_d;
  logic [W-1:0] led_q, led_d;
  dir_e         dir_q, dir_d;
  logic         phase_on_q, phase_on_d;
  logic [2:0]   mode_q, mode_d;
  logic         step_tick_q, step_tick_d;
  logic         step;
  logic         mode_chg;
  logic [W:0]   bounce_r;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .En   (bus.En),
    .Clear(bus.Load),
    .Tick (step)
  );

  // Returns {dir_is_right, next_pattern}; empty or pinned-at-both-ends patterns hold.
  function automatic logic [W:0] bounce_step(input logic [W-1:0] p, input dir_e d);
    logic [W:0] r;
    if ((p == '0) || (p[W-1] && p[0])) begin
      r = {d == DIR_RIGHT, p};
    end else if (d == DIR_LEFT) begin
      r = p[W-1] ? {1'b1, p >> 1} : {1'b0, p << 1};
    end else begin
      r = p[0] ? {1'b0, p << 1} : {1'b1, p >> 1};
    end
    return r;
  endfunction

  assign mode_chg = (bus.Mode != mode_q);
  assign bounce_r = bounce_step(pattern_q, dir_q);

  always_comb begin
    pattern_d   = pattern_q;
    dir_d       = dir_q;
    phase_on_d  = phase_on_q;
    mode_d      = bus.Mode;
    step_tick_d = 1'b0;

    if (bus.Load) begin
      pattern_d  = bus.DataIn;
      dir_d      = DIR_LEFT;
      phase_on_d = 1'b1;
    end else if (mode_chg) begin
      dir_d      = DIR_LEFT;
      phase_on_d = 1'b1;
    end else if (step) begin
      step_tick_d = 1'b1;
      case (mode_q)
        MODE_ROTL:   pattern_d = {pattern_q[W-2:0], pattern_q[W-1]};
        MODE_ROTR:   pattern_d = {pattern_q[0], pattern_q[W-1:1]};
        MODE_BOUNCE: begin
          pattern_d = bounce_r[W-1:0];
          dir_d     = bounce_r[W] ? DIR_RIGHT : DIR_LEFT;
        end
        MODE_BLINK:  phase_on_d = ~phase_on_q;
        MODE_COUNT:  pattern_d = pattern_q + W'(1);
        default:     pattern_d = pattern_q;
      endcase
    end

    // LEDs show the post-update pattern on the same edge, blanked when disabled or blink-off.
    led_d = pattern_d;
    if (!bus.En || ((mode_d == MODE_BLINK) && !phase_on_d)) begin
      led_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pattern_q   <= '0;
      led_q       <= '0;
      dir_q       <= DIR_LEFT;
      phase_on_q  <= 1'b1;
      mode_q      <= MODE_STATIC;
      step_tick_q <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      led_q       <= led_d;
      dir_q       <= dir_d;
      phase_on_q  <= phase_on_d;
      mode_q      <= mode_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign bus.LEDOut   = led_q;
  assign bus.StepTick = step_tick_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver (8 LEDs, divide-by-4): scripted vectors plus randomized traffic vs a model.
module tb_led_pattern_driver;

  localparam int W  = 8;
  localparam int TD = 4;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] din;
    logic       load;
    int         n;
    logic [7:0] led;
    logic       tick;
  } vec_t;

  logic Clk;
  logic Rst;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[$];

  int m_pat, m_right, m_off, m_mode, m_cnt, m_led, m_tick;

  led_pattern_if #(.LED_WIDTH(W)) bus ();

  led_pattern_driver #(.LED_WIDTH(W), .TICK_DIV(TD)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour stated directly in arithmetic on integers.
  task automatic model_edge(input logic rst, en, input int mode, din, input logic load);
    bit step;
    if (rst) begin
      m_pat = 0; m_right = 0; m_off = 0; m_mode = 0; m_cnt = 0; m_led = 0; m_tick = 0;
    end else begin
      step   = en && (m_cnt == TD - 1);
      m_cnt  = (!en || load) ? 0 : (m_cnt + 1) % TD;
      m_tick = 0;
      if (load) begin
        m_pat = din; m_right = 0; m_off = 0; m_mode = mode;
      end else if (mode != m_mode) begin
        m_mode = mode; m_right = 0; m_off = 0;
      end else if (step) begin
        m_tick = 1;
        case (m_mode)
          1: m_pat = ((m_pat * 2) % (1 << W)) + (m_pat / (1 << (W - 1)));
          2: m_pat = (m_pat / 2) + (m_pat % 2) * (1 << (W - 1));
          3: if (m_pat != 0 && !(m_pat >= (1 << (W - 1)) && m_pat % 2 == 1)) begin
               if (!m_right && m_pat >= (1 << (W - 1))) m_right = 1;
               else if (m_right && m_pat % 2 == 1)      m_right = 0;
               m_pat = m_right ? m_pat / 2 : (m_pat * 2) % (1 << W);
             end
          4: m_off = !m_off;
          5: m_pat = (m_pat + 1) % (1 << W);
          default: ;
        endcase
      end
      m_led = (!en || (m_mode == 4 && m_off)) ? 0 : m_pat;
    end
  endtask

  task automatic cycle(input logic rst, en, input logic [2:0] mode, input logic [7:0] din,
                       input logic load);
    Rst        = rst;
    bus.En     = en;
    bus.Mode   = mode;
    bus.DataIn = din;
    bus.Load   = load;
    @(posedge Clk);
    model_edge(rst, en, int'(mode), int'(din), load);
    #1;
    check("model_led", 32'(bus.LEDOut), 32'(m_led));
    check("model_tick", 32'(bus.StepTick), 32'(m_tick));
  endtask

  function automatic void add(input logic rst, en, input logic [2:0] mode, input logic [7:0] din,
                              input logic load, input int n, input logic [7:0] led, input logic tick);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.din = din; v.load = load;
    v.n = n; v.led = led; v.tick = tick;
    vecs.push_back(v);
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Rst = 1'b1; bus.En = 1'b0; bus.Mode = 3'd0; bus.DataIn = '0; bus.Load = 1'b0;

    //  rst en mode din   load n   led    tick
    add(1, 1, 0, 8'hFF, 1, 1,  8'h00, 0);   // reset wins over load
    add(1, 1, 0, 8'hFF, 1, 1,  8'h00, 0);
    add(0, 1, 0, 8'hFF, 0, 1,  8'h00, 0);
    add(0, 1, 1, 8'h81, 1, 1,  8'h81, 0);   // ROTL
    add(0, 1, 1, 8'h00, 0, 3,  8'h81, 0);
    add(0, 1, 1, 8'h00, 0, 1,  8'h03, 1);
    add(0, 1, 1, 8'h00, 0, 4,  8'h06, 1);
    add(0, 1, 1, 8'h00, 0, 4,  8'h0C, 1);
    add(0, 1, 1, 8'h00, 0, 1,  8'h0C, 0);
    add(0, 1, 3, 8'h40, 1, 1,  8'h40, 0);   // BOUNCE
    add(0, 1, 3, 8'h00, 0, 4,  8'h80, 1);
    add(0, 1, 3, 8'h00, 0, 4,  8'h40, 1);
    add(0, 1, 3, 8'h00, 0, 4,  8'h20, 1);
    add(0, 1, 3, 8'h81, 1, 1,  8'h81, 0);
    add(0, 1, 3, 8'h00, 0, 12, 8'h81, 1);
    add(0, 1, 4, 8'h5A, 1, 1,  8'h5A, 0);   // BLINK + En gating
    add(0, 1, 4, 8'h00, 0, 4,  8'h00, 1);
    add(0, 1, 4, 8'h00, 0, 4,  8'h5A, 1);
    add(0, 1, 4, 8'h00, 0, 2,  8'h5A, 0);
    add(0, 0, 4, 8'h00, 0, 1,  8'h00, 0);
    add(0, 0, 4, 8'h00, 0, 3,  8'h00, 0);
    add(0, 1, 4, 8'h00, 0, 1,  8'h5A, 0);
    add(0, 1, 4, 8'h00, 0, 2,  8'h5A, 0);
    add(0, 1, 4, 8'h00, 0, 1,  8'h00, 1);
    add(0, 1, 5, 8'hFE, 1, 1,  8'hFE, 0);   // COUNT wrap, load on step
    add(0, 1, 5, 8'h00, 0, 4,  8'hFF, 1);
    add(0, 1, 5, 8'h00, 0, 4,  8'h00, 1);
    add(0, 1, 5, 8'h00, 0, 3,  8'h00, 0);
    add(0, 1, 5, 8'h10, 1, 1,  8'h10, 0);
    add(0, 1, 5, 8'h00, 0, 3,  8'h10, 0);
    add(0, 1, 5, 8'h00, 0, 1,  8'h11, 1);
    add(0, 1, 2, 8'h01, 1, 1,  8'h01, 0);   // ROTR then mode changes
    add(0, 1, 2, 8'h00, 0, 4,  8'h80, 1);
    add(0, 1, 2, 8'h00, 0, 3,  8'h80, 0);
    add(0, 1, 0, 8'h00, 0, 1,  8'h80, 0);
    add(0, 1, 0, 8'h00, 0, 8,  8'h80, 1);
    add(0, 1, 7, 8'h00, 0, 1,  8'h80, 0);
    add(0, 1, 7, 8'h00, 0, 7,  8'h80, 1);
    add(1, 1, 5, 8'h33, 1, 1,  8'h00, 0);   // reset mid-load
    add(0, 1, 0, 8'h00, 0, 1,  8'h00, 0);

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        cycle(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].din, vecs[i].load);
      end
      check($sformatf("vec%0d_led", i), 32'(bus.LEDOut), 32'(vecs[i].led));
      check($sformatf("vec%0d_tick", i), 32'(bus.StepTick), 32'(vecs[i].tick));
    end

    begin
      logic [2:0] rmode;
      rmode = 3'd1;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 23) == 0) rmode = 3'($urandom_range(0, 7));
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, rmode,
              8'($urandom), $urandom_range(0, 15) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
- Parametrised successor of the 8-bit LED latch: drives LED_WIDTH LEDs from a loadable pattern register that steps at a slow, programmable rate.
- The step rate comes from a single-cycle clock-enable tick generated in the Clk domain. No derived clock.
- Pattern modes: static, rotate left, rotate right, bounce, blink and binary count.
- Sits between board switches/register bank (DataIn, Mode, Load) and the LED pins.

Parameters:
- LED_WIDTH, 8: number of LEDs/pattern bits; must be >= 2.
- TICK_DIV, 100000000: Clk cycles per pattern step (1 Hz at 100 MHz); must be >= 2.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous active-high reset.
- En  input  1  global enable; low blanks the LEDs and freezes stepping.
- Mode  input  3  pattern mode, sampled every cycle.
- DataIn  input  LED_WIDTH  pattern load value.
- Load  input  1  single-cycle strobe; DataIn is loaded into the pattern.
- LEDOut  output  LED_WIDTH  registered LED drive.
- StepTick  output  1  registered pulse, high for one cycle after every pattern step.

Behaviour:
- Clock and reset:
  - One clock: Clk. Reset: Rst, synchronous, active-high.
  - All state updates on posedge Clk.
  - Rst=1 has priority over everything. Reset values:
    - pattern = 0, LEDOut = 0, StepTick = 0
    - tick counter = 0, dir = LEFT, blink phase = ON, mode_q = STATIC
- Tick counter:
  - Width $clog2(TICK_DIV). Counts 0..TICK_DIV-1 while En=1, then wraps.
  - step = En && (cnt == TICK_DIV-1).
  - En=0: cnt is forced to 0.
  - Load=1: cnt is forced to 0, so the first step after a load occurs exactly TICK_DIV cycles later.
- Pattern update priority, per cycle:
  1. Rst
  2. Load
  3. mode change
  4. step
- Load:
  - pattern <= DataIn, dir <= LEFT, phase <= ON.
  - Accepted even when En=0.
  - A Load coincident with step suppresses that step.
- Mode change (Mode != mode_q):
  - mode_q <= Mode, dir <= LEFT, phase <= ON.
  - Pattern is preserved; no step that cycle.
- Step action by mode_q:
  - 0 STATIC: no change.
  - 1 ROTL: pattern <= {pattern[W-2:0], pattern[W-1]}.
  - 2 ROTR: pattern <= {pattern[0], pattern[W-1:1]}.
  - 3 BOUNCE: logical shift in the dir direction.
    - If dir=LEFT and pattern[W-1]=1: dir <= RIGHT and shift right this step.
    - Mirror case at bit 0: dir <= LEFT and shift left.
    - If pattern==0, or both pattern[W-1] and pattern[0] are 1: hold, no change.
  - 4 BLINK: phase <= ~phase; pattern unchanged.
  - 5 COUNT: pattern <= pattern + 1, wrapping modulo 2^LED_WIDTH (all-ones -> 0).
  - 6, 7: reserved; behave as STATIC.
- LEDOut (registered, same edge as the state update):
  - LEDOut <= 0 when En=0 or (mode BLINK and phase OFF).
  - Otherwise LEDOut <= next pattern value.
  - A Load sampled at edge k is visible on LEDOut immediately after edge k.
- StepTick:
  - StepTick <= step && !Load && !mode change.
  - Coincides with the first cycle the stepped LEDOut is visible.
- En falling:
  - LEDOut goes to 0 on the next edge; pattern, dir and phase are retained.
  - En rising resumes from the retained state, with the counter restarting from 0.
- Rst asserted mid-step or mid-load: reset values win in that cycle.

Decomposition:
- Package led_pattern_pkg:
  - Mode constants MODE_STATIC..MODE_COUNT (3-bit).
  - DIR_LEFT / DIR_RIGHT.
  - Function for the counter width.
- Sub-module led_tick_gen (Clk, Rst, En, Clear, Tick):
  - Parameter TICK_DIV.
  - Produces step; reusable elsewhere as the replacement for derived slow clocks.

Test Plan (LED_WIDTH=8, TICK_DIV=4):
- Reset: Rst high for 2 cycles with En=1, Load=1, DataIn=8'hFF -> LEDOut=0, StepTick=0 throughout reset; first cycle after release: pattern 0, LEDOut 0.
- ROTL: Load 8'h81, Mode=1, En=1 -> LEDOut 8'h81 after the load edge; then 8'h03, 8'h06, 8'h0C on successive steps every 4 cycles, with a StepTick pulse on each change.
- BOUNCE reversal: Load 8'h40, Mode=3 -> 8'h80, 8'h40, 8'h20 (dir flips at MSB); Load 8'h81 in BOUNCE -> LEDOut stays 8'h81 across 3 steps, no change.
- BLINK and En gating:
  - Load 8'h5A, Mode=4 -> LEDOut 8'h5A, 0, 8'h5A per step.
  - Drop En mid-sequence -> LEDOut 0 next edge.
  - Raise En -> 8'h5A restored, with the next step 4 cycles later.
- COUNT wrap with Load collision:
  - Load 8'hFE, Mode=5 -> 8'hFF, then 8'h00.
  - Assert Load=1 with DataIn=8'h10 exactly on a step cycle -> LEDOut 8'h10, no StepTick that cycle; next step 4 cycles later gives 8'h11.
- Mode change mid-run: ROTR on 8'h01 (next value 8'h80), switch Mode to 2->0 -> pattern frozen, no StepTick on the change cycle; reserved Mode=7 also holds.
